intercpu_shared_cluster: RTL and testbench

Parametrised successor to the combinational inter-CPU SB select. Holds the shared B registers and semaphores of all CPU clusters as state. Serves N_CPU requesting CPUs with registered reads, round-robin-arbitrated writes, and atomic semaphore test-and-set and clear. Sits between the per-CPU issue logic and the cluster resources, replacing the external SB storage plus mux.

---
 rtl/intercpu_shared_cluster_pkg.sv | 21 ++
 rtl/intercpu_shared_cluster_if.sv | 22 ++
 rtl/intercpu_shared_cluster_rr_arbiter.sv | 41 ++++
 rtl/intercpu_shared_cluster.sv | 126 ++++++++++++
 tb/tb_intercpu_shared_cluster.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/intercpu_shared_cluster_pkg.sv
// Shared definitions for the inter-CPU shared cluster: op codes, default sizes
// and the cluster-number legality check.
package intercpu_shared_cluster_pkg;

   localparam int unsigned N_SB_DEF  = 8;
   localparam int unsigned SB_W_DEF  = 24;
   localparam int unsigned N_SEM_DEF = 32;

   typedef enum logic [1:0] {
      OP_RD_SB   = 2'b00,
      OP_WR_SB   = 2'b01,
      OP_TS_SEM  = 2'b10,
      OP_CLR_SEM = 2'b11
   } op_e;

   // Cluster numbers are 1-based; 0 and anything above n_cluster are illegal
   function automatic logic cln_legal(input int unsigned cln, input int unsigned n_cluster);
      return (cln != 0) && (cln <= n_cluster);
   endfunction

endpackage

// File: rtl/intercpu_shared_cluster_if.sv
// Per-CPU request/response bundle between the issue logic and the shared cluster.
interface intercpu_shared_cluster_if #(
   parameter int unsigned N_CPU = 2,
   parameter int unsigned CLN_W = 3,
   parameter int unsigned J_W   = 5,
   parameter int unsigned SB_W  = 24
);
   logic [N_CPU*CLN_W-1:0] i_cln;
   logic [N_CPU-1:0]       i_req;
   logic [N_CPU*2-1:0]     i_op;
   logic [N_CPU*J_W-1:0]   i_j;
   logic [N_CPU*SB_W-1:0]  i_wdata;
   logic [N_CPU-1:0]       o_gnt;
   logic [N_CPU-1:0]       o_valid;
   logic [N_CPU*SB_W-1:0]  o_rdata;
   logic [N_CPU-1:0]       o_sem_old;

   modport master (output i_cln, i_req, i_op, i_j, i_wdata,
                   input  o_gnt, o_valid, o_rdata, o_sem_old);
   modport slave  (input  i_cln, i_req, i_op, i_j, i_wdata,
                   output o_gnt, o_valid, o_rdata, o_sem_old);
endinterface

// File: rtl/intercpu_shared_cluster_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module intercpu_shared_cluster_rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt_c
);
   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptr_nxt;
   logic [PTR_W-1:0] w_idx;
   int unsigned      w_pos;
   logic             w_found;

   always_comb begin
      o_gnt_c   = '0;
      w_ptr_nxt = r_ptr;
      w_found   = 1'b0;
      w_pos     = 0;
      w_idx     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_pos = 32'(r_ptr) + i;
         if (w_pos >= N) w_pos = w_pos - N;
         w_idx = PTR_W'(w_pos);
         if (!w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            o_gnt_c[w_idx] = 1'b1;
            w_ptr_nxt      = (w_pos + 1 >= N) ? '0 : PTR_W'(w_pos + 1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_ptr <= '0;
      else          r_ptr <= w_ptr_nxt;
   end

endmodule

// File: rtl/intercpu_shared_cluster.sv
// Shared B registers and semaphores of all clusters, served to N_CPU requesters:
// free registered reads, round-robin arbitrated writes / test-and-set / clear.
module intercpu_shared_cluster
   import intercpu_shared_cluster_pkg::*;
#(
   parameter int unsigned N_CPU     = 2,
   parameter int unsigned N_CLUSTER = 5,
   parameter int unsigned N_SB      = N_SB_DEF,
   parameter int unsigned SB_W      = SB_W_DEF,
   parameter int unsigned N_SEM     = N_SEM_DEF,
   parameter int unsigned CLN_W     = 3,
   parameter int unsigned J_W       = 5
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   intercpu_shared_cluster_if.slave   bus
);
   localparam int unsigned CL_IDX_W = (N_CLUSTER > 1) ? $clog2(N_CLUSTER) : 1;
   localparam int unsigned SBI_W    = (N_SB > 1) ? $clog2(N_SB) : 1;
   localparam int unsigned SEMI_W   = (N_SEM > 1) ? $clog2(N_SEM) : 1;

   logic [SB_W-1:0]  r_sb  [N_CLUSTER][N_SB];
   logic [N_SEM-1:0] r_sem [N_CLUSTER];
   logic [N_CPU-1:0]      r_valid;
   logic [N_CPU*SB_W-1:0] r_rdata;
   logic [N_CPU-1:0]      r_sem_old;

   logic [CLN_W-1:0]    w_cln    [N_CPU];
   op_e                 w_op     [N_CPU];
   logic [J_W-1:0]      w_j      [N_CPU];
   logic [SB_W-1:0]     w_wd     [N_CPU];
   logic [CL_IDX_W-1:0] w_cl     [N_CPU];
   logic                w_legal  [N_CPU];
   logic [SB_W-1:0]     w_sb_rd  [N_CPU];
   logic                w_sem_rd [N_CPU];
   logic [N_CPU-1:0]    w_rd_req, w_mreq, w_agnt, w_gnt;

   logic                w_win_any, w_win_legal;
   logic [CL_IDX_W-1:0] w_win_cl;
   op_e                 w_win_op;
   logic [SBI_W-1:0]    w_win_sbi;
   logic [SEMI_W-1:0]   w_win_semi;
   logic [SB_W-1:0]     w_win_wd;

   // Unpack per-CPU fields and look up the pre-edge storage values
   always_comb begin
      w_rd_req = '0;
      w_mreq   = '0;
      for (int k = 0; k < N_CPU; k++) begin
         w_cln[k]    = bus.i_cln[k*CLN_W +: CLN_W];
         w_op[k]     = op_e'(bus.i_op[k*2 +: 2]);
         w_j[k]      = bus.i_j[k*J_W +: J_W];
         w_wd[k]     = bus.i_wdata[k*SB_W +: SB_W];
         w_legal[k]  = cln_legal(32'(w_cln[k]), N_CLUSTER);
         w_cl[k]     = CL_IDX_W'(w_cln[k] - CLN_W'(1));
         w_rd_req[k] = bus.i_req[k] && (w_op[k] == OP_RD_SB);
         w_mreq[k]   = bus.i_req[k] && (w_op[k] != OP_RD_SB);
         w_sb_rd[k]  = w_legal[k] ? r_sb[w_cl[k]][w_j[k][SBI_W-1:0]] : '0;
         w_sem_rd[k] = w_legal[k] && r_sem[w_cl[k]][w_j[k][SEMI_W-1:0]];
      end
   end

   intercpu_shared_cluster_rr_arbiter #(.N(N_CPU)) u_rr_arbiter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (w_mreq),
      .o_gnt_c (w_agnt)
   );

   assign w_gnt         = i_rst_n ? (w_rd_req | w_agnt) : '0;
   assign bus.o_gnt     = w_gnt;
   assign bus.o_valid   = r_valid;
   assign bus.o_rdata   = r_rdata;
   assign bus.o_sem_old = r_sem_old;

   // Select the single mutating winner's fields
   always_comb begin
      w_win_any   = |w_agnt;
      w_win_legal = 1'b0;
      w_win_cl    = '0;
      w_win_op    = OP_RD_SB;
      w_win_sbi   = '0;
      w_win_semi  = '0;
      w_win_wd    = '0;
      for (int k = 0; k < N_CPU; k++) begin
         if (w_agnt[k]) begin
            w_win_legal = w_legal[k];
            w_win_cl    = w_cl[k];
            w_win_op    = w_op[k];
            w_win_sbi   = w_j[k][SBI_W-1:0];
            w_win_semi  = w_j[k][SEMI_W-1:0];
            w_win_wd    = w_wd[k];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int c = 0; c < N_CLUSTER; c++) begin
            r_sem[c] <= '0;
            for (int s = 0; s < N_SB; s++) r_sb[c][s] <= '0;
         end
         r_valid   <= '0;
         r_rdata   <= '0;
         r_sem_old <= '0;
      end else begin
         r_valid <= w_gnt;
         for (int k = 0; k < N_CPU; k++) begin
            if (w_gnt[k]) begin
               if (w_op[k] == OP_RD_SB)      r_rdata[k*SB_W +: SB_W] <= w_sb_rd[k];
               else if (w_op[k] != OP_WR_SB) r_sem_old[k]            <= w_sem_rd[k];
            end
         end
         // Illegal clusters are granted but never touch storage
         if (w_win_any && w_win_legal) begin
            case (w_win_op)
               OP_WR_SB:   r_sb[w_win_cl][w_win_sbi]   <= w_win_wd;
               OP_TS_SEM:  r_sem[w_win_cl][w_win_semi] <= 1'b1;
               OP_CLR_SEM: r_sem[w_win_cl][w_win_semi] <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_intercpu_shared_cluster.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the shared registers, semaphores and round-robin order.
module tb_intercpu_shared_cluster;
   import intercpu_shared_cluster_pkg::*;

   localparam int unsigned N_CPU = 2, N_CLUSTER = 5, N_SB = 8, SB_W = 24;
   localparam int unsigned N_SEM = 32, CLN_W = 3, J_W = 5;

   logic clk, rst_n;
   intercpu_shared_cluster_if #(.N_CPU(N_CPU), .CLN_W(CLN_W), .J_W(J_W), .SB_W(SB_W)) bus ();

   intercpu_shared_cluster #(
      .N_CPU(N_CPU), .N_CLUSTER(N_CLUSTER), .N_SB(N_SB), .SB_W(SB_W),
      .N_SEM(N_SEM), .CLN_W(CLN_W), .J_W(J_W)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [N_CPU-1:0] t_req;
   int               t_op  [N_CPU];
   int               t_cln [N_CPU];
   int               t_j   [N_CPU];
   logic [SB_W-1:0]  t_wd  [N_CPU];

   logic [SB_W-1:0]  m_sb  [8][N_SB];
   logic [N_SEM-1:0] m_sem [8];
   int               m_ptr;

   int               n_chk, n_pass;
   logic [N_CPU-1:0] g_gnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic bit legal(input int c);
      return (c >= 1) && (c <= int'(N_CLUSTER));
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 8; c++) begin
         m_sem[c] = '0;
         for (int s = 0; s < int'(N_SB); s++) m_sb[c][s] = '0;
      end
      m_ptr = 0;
   endtask

   task automatic drive();
      for (int k = 0; k < int'(N_CPU); k++) begin
         bus.i_req[k]                 = t_req[k];
         bus.i_op[k*2 +: 2]           = 2'(t_op[k]);
         bus.i_cln[k*CLN_W +: CLN_W]  = CLN_W'(t_cln[k]);
         bus.i_j[k*J_W +: J_W]        = J_W'(t_j[k]);
         bus.i_wdata[k*SB_W +: SB_W]  = t_wd[k];
      end
   endtask

   task automatic set_req(input int k, input int op, input int cln, input int j, input logic [SB_W-1:0] wd);
      t_req[k] = 1'b1;
      t_op[k]  = op;
      t_cln[k] = cln;
      t_j[k]   = j;
      t_wd[k]  = wd;
   endtask

   // One clock: check grants mid-cycle, update model, check results after the edge
   task automatic step();
      logic [N_CPU-1:0] e_gnt;
      logic [SB_W-1:0]  e_rd [N_CPU];
      logic             e_so [N_CPU];
      int               win, k, c;
      drive();
      #2;
      e_gnt = '0;
      win   = -1;
      for (int i = 0; i < int'(N_CPU); i++)
         if (t_req[i] && t_op[i] == 0) e_gnt[i] = 1'b1;
      for (int i = 0; i < int'(N_CPU); i++) begin
         k = (m_ptr + i) % int'(N_CPU);
         if (win < 0 && t_req[k] && t_op[k] != 0) begin
            win      = k;
            e_gnt[k] = 1'b1;
         end
      end
      g_gnt = bus.o_gnt;
      chk("gnt", 32'(g_gnt), 32'(e_gnt));
      for (int i = 0; i < int'(N_CPU); i++) begin
         c       = t_cln[i];
         e_rd[i] = legal(c) ? m_sb[c][t_j[i] % int'(N_SB)] : '0;
         e_so[i] = legal(c) ? m_sem[c][t_j[i] % int'(N_SEM)] : 1'b0;
      end
      if (win >= 0) begin
         m_ptr = (win + 1) % int'(N_CPU);
         c     = t_cln[win];
         if (legal(c)) begin
            if (t_op[win] == 1)      m_sb[c][t_j[win] % int'(N_SB)]   = t_wd[win];
            else if (t_op[win] == 2) m_sem[c][t_j[win] % int'(N_SEM)] = 1'b1;
            else if (t_op[win] == 3) m_sem[c][t_j[win] % int'(N_SEM)] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("valid", 32'(bus.o_valid), 32'(e_gnt));
      for (int i = 0; i < int'(N_CPU); i++) begin
         if (e_gnt[i] && t_op[i] == 0)
            chk($sformatf("rdata%0d", i), 32'(bus.o_rdata[i*SB_W +: SB_W]), 32'(e_rd[i]));
         else if (e_gnt[i] && t_op[i] >= 2)
            chk($sformatf("sem_old%0d", i), 32'(bus.o_sem_old[i]), 32'(e_so[i]));
      end
      t_req = t_req & ~g_gnt;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      t_req = '0;
      for (int k = 0; k < int'(N_CPU); k++) begin
         t_op[k] = 0; t_cln[k] = 0; t_j[k] = 0; t_wd[k] = '0;
      end
      model_reset();
      rst_n = 1'b1;
      drive();
      #1 rst_n = 1'b0;
      set_req(0, 0, 1, 0, '0);
      drive();
      #1;
      chk("rst_gnt", 32'(bus.o_gnt), 32'h0);
      chk("rst_valid", 32'(bus.o_valid), 32'h0);
      chk("rst_rdata", 32'(bus.o_rdata), 32'h0);
      chk("rst_sem_old", 32'(bus.o_sem_old), 32'h0);
      t_req = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Every SB of cluster 1 reads zero after reset
      for (int s = 0; s < int'(N_SB); s++) begin
         set_req(0, 0, 1, s, '0);
         step();
      end

      // Write cluster 2 SB3, read it back from the other CPU; cluster 3 untouched
      set_req(0, 1, 2, 3, 24'hABCDEF);
      step();
      set_req(1, 0, 2, 3, '0);
      step();
      chk("c2sb3_rd", 32'(bus.o_rdata[SB_W +: SB_W]), 32'h00ABCDEF);
      set_req(1, 0, 3, 3, '0);
      step();
      chk("c3sb3_rd", 32'(bus.o_rdata[SB_W +: SB_W]), 32'h0);

      // Pointer back to 0, then two write collisions
      set_req(1, 1, 4, 0, 24'h000001);
      step();
      set_req(0, 1, 4, 1, 24'h111111);
      set_req(1, 1, 4, 2, 24'h222222);
      step();
      chk("coll1_first", 32'(g_gnt), 32'h1);
      step();
      chk("coll1_second", 32'(g_gnt), 32'h2);
      set_req(0, 1, 4, 3, 24'h333333);
      set_req(1, 1, 4, 4, 24'h444444);
      step();
      step();

      // Simultaneous test-and-set on cluster 1 sem 5, then clear and retry
      set_req(0, 2, 1, 5, '0);
      set_req(1, 2, 1, 5, '0);
      step();
      chk("ts_first_old", 32'(bus.o_sem_old[0]), 32'h0);
      step();
      chk("ts_second_old", 32'(bus.o_sem_old[1]), 32'h1);
      set_req(0, 3, 1, 5, '0);
      step();
      set_req(1, 2, 1, 5, '0);
      step();
      chk("ts_after_clr", 32'(bus.o_sem_old[1]), 32'h0);

      // Read and write of the same register in one cycle sees the old value
      set_req(0, 1, 2, 1, 24'h000001);
      step();
      set_req(0, 1, 2, 1, 24'h000002);
      set_req(1, 0, 2, 1, '0);
      step();
      chk("rw_same_old", 32'(bus.o_rdata[SB_W +: SB_W]), 32'h000001);
      set_req(1, 0, 2, 1, '0);
      step();
      chk("rw_same_new", 32'(bus.o_rdata[SB_W +: SB_W]), 32'h000002);

      // Illegal cluster 0: granted, no effect, reads zero
      set_req(0, 1, 0, 1, 24'hFFFFFF);
      step();
      chk("cl0_wr_gnt", 32'(g_gnt), 32'h1);
      set_req(0, 0, 0, 1, '0);
      step();
      chk("cl0_rd", 32'(bus.o_rdata[0 +: SB_W]), 32'h0);

      // Random traffic with occasional withdrawals
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int k = 0; k < int'(N_CPU); k++) begin
            if (!t_req[k] && $urandom_range(0, 9) < 6)
               set_req(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 31)), SB_W'($urandom));
            else if (t_req[k] && $urandom_range(0, 19) == 0)
               t_req[k] = 1'b0;
         end
         step();
      end

      // Asynchronous reset while results are valid and a write is pending
      t_req = '0;
      set_req(0, 0, 2, 1, '0);
      set_req(1, 0, 4, 2, '0);
      step();
      set_req(1, 1, 2, 1, 24'h5A5A5A);
      drive();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(bus.o_valid), 32'h0);
      chk("midrst_gnt", 32'(bus.o_gnt), 32'h0);
      model_reset();
      t_req = '0;
      drive();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 1; c <= int'(N_CLUSTER); c++)
         for (int s = 0; s < int'(N_SB); s++) begin
            set_req(0, 0, c, s, '0);
            step();
         end
      set_req(1, 2, 1, 5, '0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
